// File: rtl/airport_security_pkg.sv
// Shared class codes, FSM encoding and default limits
// for the airport security lane scheduler.
package airport_security_pkg;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int SCAN_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        CLS_REG  = 2'd0,
        CLS_CREW = 2'd1,
        CLS_VIP  = 2'd2
    } class_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_SCAN  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ALARM = 3'd4
    } state_e;

    function automatic class_e onehot_class(input logic [2:0] oh);
        class_e c;
        c = CLS_REG;
        if (oh[2])
            c = CLS_VIP;
        else if (oh[1])
            c = CLS_CREW;
        return c;
    endfunction

endpackage

// File: rtl/lane_arbiter.sv
// Priority arbiter VIP > crew > regular with a VIP streak
// limit so pending non-VIP passengers are not starved.
module lane_arbiter
    import airport_security_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req,
    input  logic       update,
    output logic [2:0] sel
);

    localparam int SW = $clog2(STARVE_LIMIT + 2);

    logic [SW-1:0] streak;
    logic          starve;

    // Select the winner from the current requests and streak
    always_comb begin
        sel    = 3'b000;
        starve = req[2] && (req[1:0] != 2'b00)
                 && (streak == SW'(STARVE_LIMIT));
        if (starve && req[1])
            sel = 3'b010;
        else if (starve)
            sel = 3'b001;
        else if (req[2])
            sel = 3'b100;
        else if (req[1])
            sel = 3'b010;
        else if (req[0])
            sel = 3'b001;
    end

    // Count VIP wins that bypassed a waiting non-VIP passenger
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            streak <= '0;
        else if (update) begin
            if (sel[2] && (req[1:0] != 2'b00))
                streak <= streak + 1'b1;
            else
                streak <= '0;
        end
    end

endmodule

// File: rtl/airport_lane_scheduler.sv
// Security lane scheduler: grants one passenger class,
// drives the shared scanner and tracks completions.
module airport_lane_scheduler
    import airport_security_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int SCAN_TIMEOUT = SCAN_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic [23:0] bag_data,
    input  logic        scan_done,
    input  logic        alarm_clr,
    output logic [2:0]  grant,
    output logic        scan_start,
    output logic [7:0]  scan_data,
    output logic [1:0]  scan_class,
    output logic        busy,
    output logic        alarm,
    output logic [11:0] served_cnt
);

    localparam int TW = $clog2(SCAN_TIMEOUT + 1);

    state_e        state, next_state;
    logic [2:0]    arb_sel;
    logic [2:0]    sel_q;
    class_e        cls_q;
    logic [7:0]    data_q;
    logic [TW-1:0] timer;
    logic [11:0]   served;
    logic          arb_update;
    logic          done_hit;

    assign arb_update = (state == ST_IDLE) && (req != 3'b000);
    assign done_hit   = (state == ST_WAIT) && scan_done;
    assign scan_data  = data_q;
    assign scan_class = cls_q;
    assign served_cnt = served;

    lane_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .update (arb_update),
        .sel    (arb_sel)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next state and per-state outputs; timer counts finished
    // WAIT cycles, so the last allowed one sees TIMEOUT-1
    always_comb begin
        next_state = state;
        grant      = 3'b000;
        scan_start = 1'b0;
        busy       = 1'b1;
        alarm      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (req != 3'b000)
                    next_state = ST_GRANT;
            end
            ST_GRANT: begin
                grant      = sel_q;
                next_state = ST_SCAN;
            end
            ST_SCAN: begin
                scan_start = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (scan_done)
                    next_state = ST_IDLE;
                else if (timer == TW'(SCAN_TIMEOUT - 1))
                    next_state = ST_ALARM;
            end
            ST_ALARM: begin
                alarm = 1'b1;
                if (alarm_clr)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Capture the arbitration result and baggage byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q  <= 3'b000;
            cls_q  <= CLS_REG;
            data_q <= 8'h00;
        end else if (arb_update) begin
            sel_q <= arb_sel;
            cls_q <= onehot_class(arb_sel);
            if (arb_sel[2])
                data_q <= bag_data[23:16];
            else if (arb_sel[1])
                data_q <= bag_data[15:8];
            else
                data_q <= bag_data[7:0];
        end
    end

    // Scan timeout timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            timer <= '0;
        else if (state == ST_SCAN)
            timer <= '0;
        else if ((state == ST_WAIT) && !scan_done)
            timer <= timer + 1'b1;
    end

    // Saturating per-class completion counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            served <= 12'h000;
        else if (done_hit) begin
            case (cls_q)
                CLS_VIP:
                    if (served[11:8] != 4'hF)
                        served[11:8] <= served[11:8] + 4'd1;
                CLS_CREW:
                    if (served[7:4] != 4'hF)
                        served[7:4] <= served[7:4] + 4'd1;
                default:
                    if (served[3:0] != 4'hF)
                        served[3:0] <= served[3:0] + 4'd1;
            endcase
        end
    end

endmodule

// File: tb/tb_airport_lane_scheduler.sv
// Self-checking bench for airport_lane_scheduler: vector
// table, corner sequences and randomized model comparison.
module tb_airport_lane_scheduler;

    localparam int STARVE = 4;
    localparam int TMO    = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req;
    logic [23:0] bag_data;
    logic        scan_done;
    logic        alarm_clr;
    logic [2:0]  grant;
    logic        scan_start;
    logic [7:0]  scan_data;
    logic [1:0]  scan_class;
    logic        busy;
    logic        alarm;
    logic [11:0] served_cnt;

    int checks = 0;
    int errors = 0;

    int m_served[3];
    int m_streak;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] bag;
        int          d;
        logic [2:0]  exp_g;
    } vec_t;

    vec_t tbl[5];

    airport_lane_scheduler #(
        .STARVE_LIMIT(STARVE),
        .SCAN_TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .bag_data  (bag_data),
        .scan_done (scan_done),
        .alarm_clr (alarm_clr),
        .grant     (grant),
        .scan_start(scan_start),
        .scan_data (scan_data),
        .scan_class(scan_class),
        .busy      (busy),
        .alarm     (alarm),
        .served_cnt(served_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] model_cnt();
        return {4'(m_served[2]), 4'(m_served[1]), 4'(m_served[0])};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) m_served[i] = 0;
        m_streak = 0;
    endfunction

    // Who should win: strict priority, except a VIP run of
    // STARVE wins with others waiting yields to the best non-VIP
    function automatic logic [2:0] model_pick(input logic [2:0] r);
        logic [2:0] g;
        logic       others;
        others = (r[1] || r[0]);
        if (r[2] && others && m_streak >= STARVE)
            g = r[1] ? 3'b010 : 3'b001;
        else if (r[2])
            g = 3'b100;
        else if (r[1])
            g = 3'b010;
        else
            g = 3'b001;
        if (g == 3'b100 && others)
            m_streak = m_streak + 1;
        else
            m_streak = 0;
        return g;
    endfunction

    function automatic int cls_of(input logic [2:0] g);
        return g[2] ? 2 : (g[1] ? 1 : 0);
    endfunction

    // One full passenger: grant, scan, d idle WAIT cycles, done
    task automatic run_txn(input logic [2:0] r, input logic [23:0] bag,
                           input int d, input bit hold,
                           input logic [2:0] exp_g);
        int c;
        logic [23:0] b;
        b = bag;
        c = cls_of(exp_g);
        req = r;
        bag_data = bag;
        step();
        chk("grant", 32'(grant), 32'(exp_g));
        chk("scan_class", 32'(scan_class), 32'(c));
        chk("scan_data", 32'(scan_data), 32'(b[c*8 +: 8]));
        if (!hold) req = 3'b000;
        bag_data = ~bag;
        step();
        chk("scan_start", 32'(scan_start), 32'd1);
        chk("scan_data_hold", 32'(scan_data), 32'(b[c*8 +: 8]));
        step();
        repeat (d) step();
        chk("no_alarm", 32'(alarm), 32'd0);
        scan_done = 1'b1;
        step();
        scan_done = 1'b0;
        if (m_served[c] < 15) m_served[c]++;
        chk("served_cnt", 32'(served_cnt), 32'(model_cnt()));
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [2:0] g;
        logic [2:0] r;
        logic [2:0] starve_exp [6];
        int n;

        tbl[0] = '{3'b001, 24'h5A3CAA, 2, 3'b001};
        tbl[1] = '{3'b111, 24'hC1B2A3, 2, 3'b100};
        tbl[2] = '{3'b010, 24'h123456, 1, 3'b010};
        tbl[3] = '{3'b110, 24'h9988FF, TMO - 1, 3'b100};
        tbl[4] = '{3'b011, 24'h0F1E2D, 0, 3'b010};
        starve_exp[0] = 3'b100;
        starve_exp[1] = 3'b100;
        starve_exp[2] = 3'b100;
        starve_exp[3] = 3'b100;
        starve_exp[4] = 3'b001;
        starve_exp[5] = 3'b100;

        reset_n   = 1'b0;
        req       = 3'b000;
        bag_data  = 24'h0;
        scan_done = 1'b0;
        alarm_clr = 1'b0;
        model_reset();
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_scan_start", 32'(scan_start), 32'd0);
        chk("rst_cnt", 32'(served_cnt), 32'd0);
        chk("rst_data", 32'({scan_data, scan_class}), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        // Vector table
        for (int i = 0; i < 5; i++) begin
            g = model_pick(tbl[i].req);
            chk("model_vs_table", 32'(g), 32'(tbl[i].exp_g));
            run_txn(tbl[i].req, tbl[i].bag, tbl[i].d, 1'b0,
                    tbl[i].exp_g);
        end

        // Starvation: VIP and regular held together
        for (int i = 0; i < 6; i++) begin
            g = model_pick(3'b101);
            run_txn(3'b101, 24'hAB00CD, 2, 1'b1, starve_exp[i]);
        end
        req = 3'b000;
        step();

        // scan_done outside WAIT must be ignored
        g = model_pick(3'b001);
        req = 3'b001;
        step();
        chk("ign_grant", 32'(grant), 32'(g));
        req = 3'b000;
        scan_done = 1'b1;
        step();
        step();
        scan_done = 1'b0;
        step();
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_cnt", 32'(served_cnt), 32'(model_cnt()));
        scan_done = 1'b1;
        step();
        scan_done = 1'b0;
        m_served[0]++;
        chk("ign_done_cnt", 32'(served_cnt), 32'(model_cnt()));

        // Timeout into ALARM
        g = model_pick(3'b010);
        req = 3'b010;
        step();
        req = 3'b000;
        step();
        step();
        n = 0;
        while (!alarm && n < 40) begin
            step();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'(TMO));
        chk("timeout_cnt", 32'(served_cnt), 32'(model_cnt()));
        req = 3'b111;
        scan_done = 1'b1;
        repeat (3) step();
        scan_done = 1'b0;
        chk("alarm_hold", 32'(alarm), 32'd1);
        chk("alarm_no_grant", 32'(grant), 32'd0);
        chk("alarm_cnt", 32'(served_cnt), 32'(model_cnt()));
        req = 3'b000;
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
        chk("alarm_clr", 32'(alarm), 32'd0);
        chk("alarm_clr_busy", 32'(busy), 32'd0);

        // Saturation of crew counter
        for (int i = 0; i < 17; i++) begin
            g = model_pick(3'b010);
            run_txn(3'b010, 24'h00EE00, 0, 1'b0, g);
        end
        chk("crew_sat", 32'(served_cnt[7:4]), 32'd15);

        // Randomized against the model
        for (int i = 0; i < 30; i++) begin
            r = 3'($urandom_range(1, 7));
            g = model_pick(r);
            run_txn(r, 24'($urandom), int'($urandom_range(0, TMO - 1)),
                    1'b0, g);
        end

        // Reset in the middle of WAIT
        req = 3'b001;
        step();
        req = 3'b000;
        step();
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt", 32'(served_cnt), 32'd0);
        chk("mid_rst_data", 32'({scan_data, scan_class}), 32'd0);
        chk("mid_rst_pulses", 32'({grant, scan_start, alarm}), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        scan_done = 1'b1;
        step();
        scan_done = 1'b0;
        step();
        chk("post_rst_cnt", 32'(served_cnt), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        g = model_pick(3'b100);
        run_txn(3'b100, 24'h77_0000, 3, 1'b0, g);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
